// File: rtl/iiitb_sipo_deser_if.sv
// -----------------------------------------------------------------------------
// iiitb_sipo_deser_if
//   Bundles the serial receive side and the parallel valid/ready output side of
//   the SIPO deserializer.
//
//   Signals
//     ser_in     serial data bit
//     ser_valid  ser_in holds a valid bit this cycle
//     sync       with ser_valid=1, marks bit 0 of a new word
//     dir        0 = MSB-first, 1 = LSB-first (sampled on bit 0 of each word)
//     data_out   completed word
//     out_valid  data_out holds an unconsumed word
//     out_ready  consumer accepts data_out when out_valid=1
//     overrun    sticky flag: a completed word was dropped
//     busy       a partial, aligned word is being collected
//
//   Modports
//     master  stream source and output consumer (drives serial side, out_ready)
//     slave   the deserializer itself
// -----------------------------------------------------------------------------
interface iiitb_sipo_deser_if #(
   parameter int unsigned MSB = 8
) ();

   logic           ser_in;
   logic           ser_valid;
   logic           sync;
   logic           dir;
   logic [MSB-1:0] data_out;
   logic           out_valid;
   logic           out_ready;
   logic           overrun;
   logic           busy;

   modport master (
      output ser_in,
      output ser_valid,
      output sync,
      output dir,
      output out_ready,
      input  data_out,
      input  out_valid,
      input  overrun,
      input  busy
   );

   modport slave (
      input  ser_in,
      input  ser_valid,
      input  sync,
      input  dir,
      input  out_ready,
      output data_out,
      output out_valid,
      output overrun,
      output busy
   );

endinterface

// File: rtl/iiitb_sipo_deser.sv
// -----------------------------------------------------------------------------
// iiitb_sipo_deser
//   Serial-in / parallel-out deserializer. Receives the serial stream produced
//   by the universal shift register in its shift-left / shift-right modes,
//   assembles MSB-bit words framed by sync, and presents each finished word on
//   a registered, single-entry valid/ready output. The serial side is never
//   stalled: a word finishing while the output slot is still occupied and not
//   being consumed is dropped and flagged on the sticky overrun output.
//
//   Ports
//     clock   single clock, all state updates on the rising edge
//     clear   synchronous active-high reset, highest priority
//     bus     iiitb_sipo_deser_if.slave
//               in : ser_in, ser_valid, sync, dir, out_ready
//               out: data_out, out_valid, overrun, busy
// -----------------------------------------------------------------------------
module iiitb_sipo_deser #(
   parameter int unsigned MSB = 8
) (
   input  logic                     clock,
   input  logic                     clear,
   iiitb_sipo_deser_if.slave        bus
);

   localparam int unsigned CntW = $clog2(MSB + 1);

   // HUNT: no word alignment yet, unframed bits are discarded.
   // SHIFT: aligned; cnt_q counts the bits of the current word held so far.
   typedef enum logic {
      StHunt,
      StShift
   } state_e;

   state_e              state_q,     state_d;
   logic [MSB-1:0]      shreg_q,     shreg_d;
   logic [CntW-1:0]     cnt_q,       cnt_d;
   logic                dir_l_q,     dir_l_d;
   logic [MSB-1:0]      data_out_q,  data_out_d;
   logic                out_valid_q, out_valid_d;
   logic                overrun_q,   overrun_d;

   // Intermediate next-state terms
   logic                accept;
   logic                first_bit;
   logic                dir_eff;
   logic [MSB-1:0]      shreg_base;
   logic [CntW-1:0]     cnt_base;
   logic [MSB-1:0]      shreg_shift;
   logic                complete;
   logic                transfer;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (clear) begin
         state_q     <= StHunt;
         shreg_q     <= '0;
         cnt_q       <= '0;
         dir_l_q     <= 1'b0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         dir_l_q     <= dir_l_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      dir_l_d     = dir_l_q;
      data_out_d  = data_out_q;
      out_valid_d = out_valid_q;
      overrun_d   = overrun_q;

      // A bit is taken when valid and either already aligned or it carries sync.
      // sync without ser_valid is meaningless and falls out here.
      accept = bus.ser_valid && ((state_q == StShift) || bus.sync);

      // sync restarts the word, dropping whatever partial word was held.
      shreg_base = bus.sync ? '0 : shreg_q;
      cnt_base   = bus.sync ? '0 : cnt_q;

      // Direction is decided by bit 0 alone; later dir changes are ignored, so
      // the bit-0 value must be used directly rather than the latched copy.
      first_bit = (cnt_base == '0);
      dir_eff   = first_bit ? bus.dir : dir_l_q;

      if (dir_eff) begin
         shreg_shift = {bus.ser_in, shreg_base[MSB-1:1]};
      end else begin
         shreg_shift = {shreg_base[MSB-2:0], bus.ser_in};
      end

      complete = accept && (cnt_base == CntW'(MSB - 1));
      transfer = out_valid_q && bus.out_ready;

      case (state_q)
         StHunt: begin
            if (accept) begin
               state_d = StShift;
            end
         end
         StShift: begin
            state_d = StShift;
         end
         default: begin
            state_d = StHunt;
         end
      endcase

      if (accept) begin
         shreg_d = shreg_shift;
         dir_l_d = dir_eff;
         cnt_d   = complete ? '0 : cnt_base + CntW'(1);
      end

      // Single-entry output slot. A finished word may replace the current one
      // only if the slot is empty or being consumed in this same cycle.
      if (complete) begin
         if (!out_valid_q || bus.out_ready) begin
            data_out_d  = shreg_shift;
            out_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (transfer) begin
         out_valid_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.data_out  = data_out_q;
   assign bus.out_valid = out_valid_q;
   assign bus.overrun   = overrun_q;
   assign bus.busy      = (state_q == StShift) && (cnt_q != '0);

endmodule

// File: tb/tb_iiitb_sipo_deser.sv
// -----------------------------------------------------------------------------
// tb_iiitb_sipo_deser
//   Self-checking bench for iiitb_sipo_deser (MSB = 8). A reference model keeps
//   the bits of the word in progress in a queue and builds the word with plain
//   arithmetic once eight bits have arrived.
// -----------------------------------------------------------------------------
module tb_iiitb_sipo_deser;

   localparam int unsigned MSB = 8;

   logic clock;
   logic clear;

   iiitb_sipo_deser_if #(.MSB(MSB)) bus ();

   iiitb_sipo_deser #(.MSB(MSB)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit             m_aligned;
   bit             m_bits[$];
   bit             m_dir;
   logic [MSB-1:0] m_data;
   bit             m_valid;
   bit             m_ovr;

   function automatic logic [MSB-1:0] build_word();
      logic [MSB-1:0] w;
      w = '0;
      for (int i = 0; i < MSB; i++) begin
         if (m_bits[i]) begin
            if (m_dir) w = w | (MSB'(1) << i);
            else       w = w | (MSB'(1) << (MSB - 1 - i));
         end
      end
      return w;
   endfunction

   function automatic bit m_busy();
      return m_aligned && (m_bits.size() != 0);
   endfunction

   // Apply one cycle of inputs, advance the model, return #1 after the edge.
   task automatic drive(input bit clr, input bit sv, input bit si, input bit sy,
                        input bit d, input bit rdy);
      bit             done;
      logic [MSB-1:0] w;
      @(negedge clock);
      clear         = clr;
      bus.ser_valid = sv;
      bus.ser_in    = si;
      bus.sync      = sy;
      bus.dir       = d;
      bus.out_ready = rdy;
      done = 1'b0;
      w    = '0;
      if (clr) begin
         m_aligned = 1'b0;
         m_bits.delete();
         m_dir   = 1'b0;
         m_data  = '0;
         m_valid = 1'b0;
         m_ovr   = 1'b0;
      end else begin
         if (sv && (sy || m_aligned)) begin
            if (sy) begin
               m_bits.delete();
               m_aligned = 1'b1;
            end
            if (m_bits.size() == 0) m_dir = d;
            m_bits.push_back(si);
            if (m_bits.size() == MSB) begin
               w    = build_word();
               done = 1'b1;
               m_bits.delete();
            end
         end
         if (done) begin
            if (!m_valid || rdy) begin
               m_data  = w;
               m_valid = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (m_valid && rdy) begin
            m_valid = 1'b0;
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input bit rdy);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rdy);
   endtask

   // Send one word; dir=0 puts w[7] on the line first, dir=1 puts w[0] first.
   task automatic send_word(input logic [7:0] w, input bit d, input bit sync_first,
                            input bit toggle, input bit rdy, input bit rdy_last);
      bit b;
      for (int i = 0; i < MSB; i++) begin
         b = d ? w[i] : w[MSB-1-i];
         drive(1'b0, 1'b1, b, (i == 0) && sync_first, (toggle && i > 0) ? ~d : d,
               (i == MSB - 1) ? rdy_last : rdy);
      end
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.data_out !== 8'h00) begin
         errors++; $display("FAIL reset_data got %h want 00", bus.data_out);
      end
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid);
      end
      checks++;
      if (bus.overrun !== 1'b0) begin
         errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy got %b want 0", bus.busy);
      end
   endtask

   task automatic test_msb_first();
      logic [7:0] seq;
      seq = 8'hB2;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         drive(1'b0, 1'b1, seq[7-i], i == 0, 1'b0, 1'b0);
      end
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL msb7_state got valid=%b busy=%b want valid=0 busy=1",
                  bus.out_valid, bus.busy);
      end
      drive(1'b0, 1'b1, seq[0], 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== 8'hB2) begin
         errors++;
         $display("FAIL msb_word got valid=%b data=%h want valid=1 data=b2",
                  bus.out_valid, bus.data_out);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL msb_busy_after got %b want 0", bus.busy);
      end
      idle(1'b1);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.data_out !== 8'hB2) begin
         errors++;
         $display("FAIL msb_consume got valid=%b data=%h want valid=0 data=b2",
                  bus.out_valid, bus.data_out);
      end
   endtask

   task automatic test_lsb_first();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(8'h4D, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== 8'h4D) begin
         errors++;
         $display("FAIL lsb_word got valid=%b data=%h want valid=1 data=4d",
                  bus.out_valid, bus.data_out);
      end
      // Same serial stream, dir flipped after bit 0; must still decode LSB-first.
      send_word(8'h4D, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== 8'h4D) begin
         errors++;
         $display("FAIL lsb_toggle got valid=%b data=%h want valid=1 data=4d",
                  bus.out_valid, bus.data_out);
      end
      checks++;
      if (bus.overrun !== 1'b0) begin
         errors++; $display("FAIL lsb_overrun got %b want 0", bus.overrun);
      end
   endtask

   task automatic test_hunt();
      bit bad;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      bad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
         if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL hunt_ignore got valid=%b busy=%b want 0 0", bus.out_valid, bus.busy);
      end
      send_word(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== 8'hA5) begin
         errors++;
         $display("FAIL hunt_word got valid=%b data=%h want valid=1 data=a5",
                  bus.out_valid, bus.data_out);
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_word(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.data_out !== 8'h3C || bus.overrun !== 1'b1 || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_drop got data=%h ovr=%b valid=%b want 3c 1 1",
                  bus.data_out, bus.overrun, bus.out_valid);
      end
      idle(1'b0);
      checks++;
      if (bus.overrun !== 1'b1) begin
         errors++; $display("FAIL b2b_sticky got %b want 1", bus.overrun);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_word(8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (bus.data_out !== 8'hC3 || bus.overrun !== 1'b0 || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_replace got data=%h ovr=%b valid=%b want c3 0 1",
                  bus.data_out, bus.overrun, bus.out_valid);
      end
   endtask

   task automatic test_gaps();
      logic [7:0] w;
      int         gap;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 1'b1, i == 0, 1'b0, 1'b0);
      end
      checks++;
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL gap_partial got busy=%b valid=%b want 1 0", bus.busy, bus.out_valid);
      end
      w = 8'h81;
      for (int i = 0; i < 8; i++) begin
         gap = $urandom_range(0, 3);
         for (int g = 0; g < gap; g++) begin
            // Junk on the line plus stray sync without ser_valid: all ignored.
            drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0);
         end
         drive(1'b0, 1'b1, w[7-i], i == 0, 1'b0, 1'b0);
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.data_out !== 8'h81) begin
         errors++;
         $display("FAIL gap_word got valid=%b data=%h want valid=1 data=81",
                  bus.out_valid, bus.data_out);
      end
   endtask

   task automatic test_clear_mid();
      bit bad;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_word(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      send_word(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b1, i == 0, 1'b0, 1'b0);
      // clear wins even with a sync-framed valid bit present.
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      checks++;
      if (bus.data_out !== 8'h00 || bus.out_valid !== 1'b0 || bus.overrun !== 1'b0 ||
          bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL clear_mid got data=%h valid=%b ovr=%b busy=%b want 00 0 0 0",
                  bus.data_out, bus.out_valid, bus.overrun, bus.busy);
      end
      bad = 1'b0;
      for (int i = 0; i < 12; i++) begin
         drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
         if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL clear_hunt got busy=%b valid=%b want 0 0", bus.busy, bus.out_valid);
      end
   endtask

   task automatic test_random();
      int bad;
      bad = 0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 3000; n++) begin
         drive(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
         checks++;
         if (bus.data_out !== m_data || bus.out_valid !== m_valid ||
             bus.overrun !== m_ovr || bus.busy !== m_busy()) begin
            errors++;
            bad++;
            if (bad <= 10) begin
               $display("FAIL random_cycle%0d got data=%h v=%b o=%b b=%b want %h %b %b %b",
                        n, bus.data_out, bus.out_valid, bus.overrun, bus.busy,
                        m_data, m_valid, m_ovr, m_busy());
            end
         end
      end
   endtask

   initial begin
      clear         = 1'b1;
      bus.ser_in    = 1'b0;
      bus.ser_valid = 1'b0;
      bus.sync      = 1'b0;
      bus.dir       = 1'b0;
      bus.out_ready = 1'b0;
      test_reset();
      test_msb_first();
      test_lsb_first();
      test_hunt();
      test_back_to_back();
      test_gaps();
      test_clear_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
